// File: rtl/add_icb_driver_if.sv
// Bundle between add_icb_driver and its environment: operand request, result and ICB master link.
// The master modport is the driver's view; the slave modport is the requester/adder side.
interface add_icb_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_ovf;
  logic        res_err;
  logic        busy;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    input  req_valid, req_a, req_b, res_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
    output req_ready, res_valid, res_sum, res_ovf, res_err, busy,
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready
  );

  modport slave (
    output req_valid, req_a, req_b, res_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
    input  req_ready, res_valid, res_sum, res_ovf, res_err, busy,
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready
  );
endinterface

// File: rtl/add_icb_driver.sv
// ICB sequencer for the adder: write operands, enable, settle, read SUM/OFSIGN, disable; 13+SETTLE_CYC cycles zero-wait,
// stalls on cmd_ready/rsp_valid/res_ready, one op in flight. ADD_ICB_DRIVER_CLEAR_EN adds a leading clear write.
module add_icb_driver #(
  parameter logic [31:0] BASE_ADDR  = 32'h1004_2000,
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  add_icb_driver_if.master bus
);

  localparam logic [31:0] OFF_AUGEND = 32'h00;
  localparam logic [31:0] OFF_ADDEND = 32'h04;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_SUM    = 32'h0C;
  localparam logic [31:0] OFF_OFSIGN = 32'h10;
  localparam logic [7:0]  SETTLE     = 8'(SETTLE_CYC);

  typedef enum logic [3:0] {
    IDLE,
`ifdef ADD_ICB_DRIVER_CLEAR_EN
    CLR,
`endif
    WR_A,
    WR_B,
    WR_EN,
    WAIT,
    RD_SUM,
    RD_OF,
    WR_DIS,
    RES
  } state_t;

  typedef struct packed {
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  function automatic state_t next_of(state_t s);
    case (s)
`ifdef ADD_ICB_DRIVER_CLEAR_EN
      IDLE:   next_of = CLR;
      CLR:    next_of = WR_A;
`else
      IDLE:   next_of = WR_A;
`endif
      WR_A:   next_of = WR_B;
      WR_B:   next_of = WR_EN;
      WR_EN:  next_of = (SETTLE == 8'd0) ? RD_SUM : WAIT;
      WAIT:   next_of = RD_SUM;
      RD_SUM: next_of = RD_OF;
      RD_OF:  next_of = WR_DIS;
      WR_DIS: next_of = RES;
      default: next_of = IDLE;
    endcase
  endfunction

  function automatic cmd_t cmd_of(state_t s, logic [31:0] a, logic [31:0] b);
    cmd_of = '0;
    case (s)
`ifdef ADD_ICB_DRIVER_CLEAR_EN
      CLR:    cmd_of = {1'b0, BASE_ADDR + OFF_CTRL,   32'h2, 4'hF};
`endif
      WR_A:   cmd_of = {1'b0, BASE_ADDR + OFF_AUGEND, a,     4'hF};
      WR_B:   cmd_of = {1'b0, BASE_ADDR + OFF_ADDEND, b,     4'hF};
      WR_EN:  cmd_of = {1'b0, BASE_ADDR + OFF_CTRL,   32'h1, 4'hF};
      RD_SUM: cmd_of = {1'b1, BASE_ADDR + OFF_SUM,    32'h0, 4'h0};
      RD_OF:  cmd_of = {1'b1, BASE_ADDR + OFF_OFSIGN, 32'h0, 4'h0};
      WR_DIS: cmd_of = {1'b0, BASE_ADDR + OFF_CTRL,   32'h0, 4'hF};
      default: cmd_of = '0;
    endcase
  endfunction

  state_t      state;
  state_t      nxt;
  cmd_t        nxt_cmd;
  cmd_t        cmd_q;
  logic        phase;
  logic        cmd_valid_q;
  logic        rsp_ready_q;
  logic        res_valid_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] sum_q;
  logic        ovf_q;
  logic        err_q;
  logic [7:0]  cnt;

  // Out of IDLE the operands are not latched yet, so the first write takes them straight from the request.
  assign nxt     = next_of(state);
  assign nxt_cmd = cmd_of(nxt, (state == IDLE) ? bus.req_a : a_q,
                               (state == IDLE) ? bus.req_b : b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_q         <= bus.req_a;
            b_q         <= bus.req_b;
            err_q       <= 1'b0;
            state       <= nxt;
            cmd_q       <= nxt_cmd;
            cmd_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state       <= nxt;
            cmd_q       <= nxt_cmd;
            cmd_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RES: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          // Bus state: CMD phase until accepted, then RSP phase until the response arrives.
          if (!phase) begin
            if (bus.icb_cmd_ready) begin
              cmd_valid_q <= 1'b0;
              rsp_ready_q <= 1'b1;
              phase       <= 1'b1;
            end
          end else if (bus.icb_rsp_valid) begin
            rsp_ready_q <= 1'b0;
            phase       <= 1'b0;
            err_q       <= err_q | bus.icb_rsp_err;
            if (state == RD_SUM) sum_q <= bus.icb_rsp_rdata;
            if (state == RD_OF)  ovf_q <= bus.icb_rsp_rdata[0];
            state <= nxt;
            if (nxt == WAIT) begin
              cnt <= SETTLE - 8'd1;
            end else if (nxt == RES) begin
              res_valid_q <= 1'b1;
            end else begin
              cmd_q       <= nxt_cmd;
              cmd_valid_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE) & ~rst;
  assign bus.busy          = (state != IDLE);
  assign bus.res_valid     = res_valid_q;
  assign bus.res_sum       = sum_q;
  assign bus.res_ovf       = ovf_q;
  assign bus.res_err       = err_q;
  assign bus.icb_cmd_valid = cmd_valid_q;
  assign bus.icb_cmd_read  = cmd_q.read;
  assign bus.icb_cmd_addr  = cmd_q.addr;
  assign bus.icb_cmd_wdata = cmd_q.wdata;
  assign bus.icb_cmd_wmask = cmd_q.wmask;
  assign bus.icb_rsp_ready = rsp_ready_q;

endmodule
